// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
package fetch_pkg;

  localparam int ADDR_W        = 8;
  localparam int DATA_W        = 32;
  localparam int FETCH_Q_DEPTH = 2;
  localparam int CNT_W         = 2;

  typedef enum logic [1:0] {F_IDLE, F_RUN, F_DRAIN} fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return a & ~{{(ADDR_W-2){1'b0}}, 2'b11};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {pc, instr} pairs; head is held in a register so
// decode never sees a combinational path from memory.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  fetch_entry_t     i_data,
  output fetch_entry_t     o_head,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_count
);

  fetch_entry_t     r_head;
  fetch_entry_t     r_tail;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  assign w_full = (r_count == CNT_W'(FETCH_Q_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (!w_full) begin
            if (r_count == '0) r_head <= i_data;
            else               r_tail <= i_data;
            r_count <= r_count + CNT_W'(1);
          end
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - CNT_W'(1);
        end
        // Simultaneous push and pop keeps the occupancy, including when full.
        2'b11: begin
          if (r_count == CNT_W'(1)) begin
            r_head <= i_data;
          end else begin
            r_head <= r_tail;
            r_tail <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_head  = r_head;
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch sequencer: PC register, run/drain FSM, single in-flight memory read
// tracker and a 2-entry return queue feeding decode over valid/ready.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_halt,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic [DATA_W-1:0] i_imem_rdata,
  output logic              o_instr_valid,
  input  logic              i_instr_ready,
  output logic [DATA_W-1:0] o_instr_data,
  output logic [ADDR_W-1:0] o_instr_pc,
  output logic              o_busy
);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_pending;
  logic [ADDR_W-1:0] r_pend_pc;

  fetch_entry_t     w_head;
  fetch_entry_t     w_push_data;
  logic             w_q_valid;
  logic [CNT_W-1:0] w_count;
  logic             w_pop;
  logic             w_push;
  logic             w_issue;
  logic [2:0]       w_inflight;

  assign w_pop      = w_q_valid & i_instr_ready;
  assign w_inflight = {1'b0, w_count} - {2'b00, w_pop} + {2'b00, r_pending};
  // Redirect and halt both suppress issue in the cycle they are asserted.
  assign w_issue    = (r_state == F_RUN) & ~i_halt & ~i_redirect_valid & (w_inflight < 3'd2);
  assign w_push     = r_pending & ~i_redirect_valid;

  assign w_push_data.pc    = r_pend_pc;
  assign w_push_data.instr = i_imem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= F_IDLE;
      r_pc      <= RESET_PC;
      r_pending <= 1'b0;
      r_pend_pc <= '0;
    end else begin
      r_pending <= w_issue;
      if (w_issue) r_pend_pc <= r_pc;

      if (i_redirect_valid) r_pc <= word_align(i_redirect_pc);
      else if (w_issue)     r_pc <= r_pc + PC_STEP;

      case (r_state)
        F_IDLE:  if (i_start && !i_halt) r_state <= F_RUN;
        F_RUN:   if (i_halt) r_state <= F_DRAIN;
        F_DRAIN: if (!r_pending && !w_q_valid) r_state <= F_IDLE;
        default: r_state <= F_IDLE;
      endcase
    end
  end

  fetch_queue u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_redirect_valid),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_valid (w_q_valid),
    .o_count (w_count)
  );

  assign o_imem_addr   = r_pc;
  assign o_instr_valid = w_q_valid;
  assign o_instr_data  = w_head.instr;
  assign o_instr_pc    = w_head.pc;
  assign o_busy        = (r_state != F_IDLE) | r_pending | w_q_valid;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed plus randomized bench for instruction_fetch_unit against a
// transaction-level model; memory returns word a*16 for byte address a.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        redirectValid = 1'b0;
  logic [7:0]  redirectPc = 8'h00;
  logic [7:0]  imemAddr;
  logic [31:0] imemRdata = 32'h0;
  logic        instrValid;
  logic        instrReady = 1'b0;
  logic [31:0] instrData;
  logic [7:0]  instrPc;
  logic        busy;

  int tests = 0;
  int fails = 0;

  // Model: mode 0 idle, 1 run, 2 drain; queue of delivered-pending PCs.
  int mMode = 0;
  int mPc = 0;
  bit mPend = 1'b0;
  int mPendPc = 0;
  int mQ[$];

  always #5 clk = ~clk;

  always @(posedge clk) imemRdata <= 32'(imemAddr) * 32'd16;

  instruction_fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .i_start          (start),
    .i_halt           (halt),
    .i_redirect_valid (redirectValid),
    .i_redirect_pc    (redirectPc),
    .o_imem_addr      (imemAddr),
    .i_imem_rdata     (imemRdata),
    .o_instr_valid    (instrValid),
    .i_instr_ready    (instrReady),
    .o_instr_data     (instrData),
    .o_instr_pc       (instrPc),
    .o_busy           (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mMode = 0;
    mPc = 0;
    mPend = 1'b0;
    mPendPc = 0;
    mQ.delete();
  endtask

  task automatic modelClock(input bit st, input bit hl, input bit rv, input int rpc, input bit rdy);
    bit pop;
    bit issue;
    int inflight;
    bit wasEmpty;
    bit wasPend;
    wasEmpty = (mQ.size() == 0);
    wasPend  = mPend;
    pop      = !wasEmpty && rdy;
    inflight = mQ.size() - int'(pop) + int'(mPend);
    issue    = (mMode == 1) && !hl && !rv && (inflight < 2);
    if (pop) void'(mQ.pop_front());
    if (rv) mQ.delete();
    else if (mPend) mQ.push_back(mPendPc);
    mPend = issue;
    if (issue) mPendPc = mPc;
    if (rv) mPc = rpc - (rpc % 4);
    else if (issue) mPc = (mPc + 4) % 256;
    if (mMode == 0 && st && !hl) mMode = 1;
    else if (mMode == 1 && hl) mMode = 2;
    else if (mMode == 2 && !wasPend && wasEmpty) mMode = 0;
  endtask

  task automatic checkModel();
    checkOutput("valid", 32'(instrValid), 32'(mQ.size() > 0));
    checkOutput("imemAddr", 32'(imemAddr), 32'(mPc));
    checkOutput("busy", 32'(busy), 32'(mMode != 0 || mPend || mQ.size() > 0));
    if (mQ.size() > 0) begin
      checkOutput("headPc", 32'(instrPc), 32'(mQ[0]));
      checkOutput("headData", instrData, 32'(mQ[0]) * 32'd16);
    end
  endtask

  // Called at a negedge: drive inputs, clock once, advance model, check.
  task automatic applyStimulus(input bit st, input bit hl, input bit rv, input int rpc, input bit rdy);
    start = st;
    halt = hl;
    redirectValid = rv;
    redirectPc = 8'(rpc);
    instrReady = rdy;
    @(posedge clk);
    modelClock(st, hl, rv, rpc, rdy);
    @(negedge clk);
    start = 1'b0;
    halt = 1'b0;
    redirectValid = 1'b0;
    checkModel();
  endtask

  initial begin
    int got[$];
    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rstValid", 32'(instrValid), 32'd0);
    checkOutput("rstData", instrData, 32'd0);
    checkOutput("rstPc", 32'(instrPc), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstAddr", 32'(imemAddr), 32'd0);
    rst = 1'b0;
    modelReset();

    // Start latency and streaming
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("lat1", 32'(instrValid), 32'd0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lat2", 32'(instrValid), 32'd0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("firstValid", 32'(instrValid), 32'd1);
    checkOutput("firstPc", 32'(instrPc), 32'd0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 1);

    // Backpressure then release
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 1);

    // Redirect to 0x43 while streaming with one read in flight
    applyStimulus(0, 0, 1, 8'h43, 1);
    for (int i = 0; i < 8 && !instrValid; i++) applyStimulus(0, 0, 0, 0, 1);
    checkOutput("redirValid", 32'(instrValid), 32'd1);
    checkOutput("redirPc", 32'(instrPc), 32'h40);
    checkOutput("redirData", instrData, 32'h400);

    // Redirect near the top of the address space and watch the wrap
    applyStimulus(0, 0, 1, 8'hF8, 1);
    for (int i = 0; i < 10; i++) begin
      if (instrValid) got.push_back(int'(instrPc));
      applyStimulus(0, 0, 0, 0, 1);
    end
    checkOutput("wrapCount", 32'(got.size() >= 4), 32'd1);
    checkOutput("wrap0", 32'(got.size() > 0 ? got[0] : -1), 32'hF8);
    checkOutput("wrap1", 32'(got.size() > 1 ? got[1] : -1), 32'hFC);
    checkOutput("wrap2", 32'(got.size() > 2 ? got[2] : -1), 32'h00);
    checkOutput("wrap3", 32'(got.size() > 3 ? got[3] : -1), 32'h04);

    // Halt with the queue full, then drain
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("haltBusy", 32'(busy), 32'd1);
    for (int i = 0; i < 8 && busy; i++) applyStimulus(0, 0, 0, 0, 1);
    checkOutput("drainBusy", 32'(busy), 32'd0);
    checkOutput("drainValid", 32'(instrValid), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 15) == 0), int'($urandom_range(0, 255)),
                    ($urandom_range(0, 3) != 0));
    end

    // Reset in the middle of a stream with a valid head
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("preRstValid", 32'(instrValid), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("asyncValid", 32'(instrValid), 32'd0);
    checkOutput("asyncBusy", 32'(busy), 32'd0);
    checkOutput("asyncAddr", 32'(imemAddr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
